// File: rtl/ysyx_lsu_pkg.sv
// Shared encodings and types for the load/store unit.
// Decoder rd_sel/wr_sel constants live here so both sides agree on them.
package ysyx_lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RD_W   = 3;
    localparam int unsigned WR_W   = 2;
    localparam int unsigned MASK_W = XLEN / 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [RD_W-1:0] RD_NONE = 3'b000;
    localparam logic [RD_W-1:0] RD_LB   = 3'b001;
    localparam logic [RD_W-1:0] RD_LBU  = 3'b010;
    localparam logic [RD_W-1:0] RD_LH   = 3'b011;
    localparam logic [RD_W-1:0] RD_LHU  = 3'b100;
    localparam logic [RD_W-1:0] RD_LW   = 3'b101;

    localparam logic [WR_W-1:0] WR_NONE = 2'b00;
    localparam logic [WR_W-1:0] WR_SB   = 2'b01;
    localparam logic [WR_W-1:0] WR_SH   = 2'b10;
    localparam logic [WR_W-1:0] WR_SW   = 2'b11;

    typedef logic [1:0] lsu_state_t;
    localparam lsu_state_t S_IDLE = 2'd0;
    localparam lsu_state_t S_REQ  = 2'd1;
    localparam lsu_state_t S_WAIT = 2'd2;
    localparam lsu_state_t S_DONE = 2'd3;

    // Request fields held for the duration of one access.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [RD_W-1:0] rd_sel;
        logic [WR_W-1:0] wr_sel;
    } lsu_req_t;

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational byte-lane steering: store mask/data replication and load
// extraction with sign/zero extension. Halfword/word lanes ignore low offset bits.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
(
    input  logic [RD_W-1:0]   rd_sel,
    input  logic [WR_W-1:0]   wr_sel,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [MASK_W-1:0] wmask_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   load_c
);

    logic [1:0]      half_off;
    logic [XLEN-1:0] byte_lane;
    logic [XLEN-1:0] half_lane;

    assign half_off  = {offset[1], 1'b0};
    assign byte_lane = rdata >> {offset, 3'b000};
    assign half_lane = rdata >> {half_off, 3'b000};

    always_comb begin
        wmask_c = '0;
        wdata_c = '0;
        case (wr_sel)
            WR_SB: begin
                wmask_c = 4'b0001 << offset;
                wdata_c = {4{wdata[7:0]}};
            end
            WR_SH: begin
                wmask_c = 4'b0011 << half_off;
                wdata_c = {2{wdata[15:0]}};
            end
            WR_SW: begin
                wmask_c = 4'b1111;
                wdata_c = wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_c = '0;
        case (rd_sel)
            RD_LB:   load_c = {{24{byte_lane[7]}}, byte_lane[7:0]};
            RD_LBU:  load_c = {24'd0, byte_lane[7:0]};
            RD_LH:   load_c = {{16{half_lane[15]}}, half_lane[15:0]};
            RD_LHU:  load_c = {16'd0, half_lane[15:0]};
            RD_LW:   load_c = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Single-outstanding load/store unit on a valid/ready data-memory bus.
// Optional YSYX_LSU_MISALIGN_CHK_EN rejects misaligned halfword/word accesses.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RD_W-1:0]   req_rd_sel,
    input  logic [WR_W-1:0]   req_wr_sel,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    lsu_state_t       state;
    lsu_state_t       state_nxt;
    lsu_req_t         req_q;
    logic [CNT_W-1:0] cnt;
    logic             err_nxt;
    logic [XLEN-1:0]  data_nxt;
    logic             noop_c;
    logic             illegal_c;
    logic             misalign_c;
    logic             timeout_c;
    logic [XLEN-1:0]  load_c;

    assign noop_c    = (req_rd_sel == RD_NONE) && (req_wr_sel == WR_NONE);
    assign illegal_c = (req_rd_sel >= 3'b110) ||
                       ((req_rd_sel != RD_NONE) && (req_wr_sel != WR_NONE));

`ifdef YSYX_LSU_MISALIGN_CHK_EN
    assign misalign_c =
        (((req_rd_sel == RD_LH) || (req_rd_sel == RD_LHU) || (req_wr_sel == WR_SH)) && req_addr[0]) ||
        (((req_rd_sel == RD_LW) || (req_wr_sel == WR_SW)) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // A zero parameter disables the abort entirely.
    assign timeout_c = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    ysyx_lsu_align u_align (
        .rd_sel  (req_q.rd_sel),
        .wr_sel  (req_q.wr_sel),
        .offset  (req_q.addr[1:0]),
        .wdata   (req_q.wdata),
        .rdata   (mem_rdata),
        .wmask_c (mem_wmask),
        .wdata_c (mem_wdata),
        .load_c  (load_c)
    );

    assign mem_addr = {req_q.addr[XLEN-1:2], 2'b00};
    assign mem_wen  = (req_q.wr_sel != WR_NONE);

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        data_nxt  = '0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (noop_c) begin
                        state_nxt = S_DONE;
                    end else if (illegal_c || misalign_c) begin
                        state_nxt = S_DONE;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = S_DONE;
                    data_nxt  = load_c;
                end else if (timeout_c) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered off the next state; response fields are zero outside DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            req_q         <= '0;
            cnt           <= '0;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && req_valid) begin
                req_q.addr   <= req_addr;
                req_q.wdata  <= req_wdata;
                req_q.rd_sel <= req_rd_sel;
                req_q.wr_sel <= req_wr_sel;
            end
            cnt           <= (state == S_WAIT) ? cnt + CNT_W'(1) : '0;
            req_ready     <= (state_nxt == S_IDLE);
            mem_req_valid <= (state_nxt == S_REQ);
            rsp_valid     <= (state_nxt == S_DONE);
            rsp_rdata     <= data_nxt;
            rsp_err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_lsu.sv
// Self-checking bench for ysyx_lsu: directed and randomized accesses against a
// lane/extension reference model; honours YSYX_LSU_MISALIGN_CHK_EN.
module tb_ysyx_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_rd_sel;
    logic [1:0]  req_wr_sel;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_lsu #(.TIMEOUT_CYCLES(255)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd_sel    (req_rd_sel),
        .req_wr_sel    (req_wr_sel),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wmask     (mem_wmask),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err)
    );

    // One full access, driven and sampled on falling edges; acceptance edge is "edge 0".
    task automatic run_txn(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int ready_dly, input int rsp_dly, input string tag);
        logic        illegal, noop, misal, bus, err;
        logic [3:0]  emask;
        logic [31:0] ewdata, eload, lane;
        int          off;
        off     = int'(addr % 4);
        noop    = (rd == 0) && (wr == 0);
        illegal = (rd >= 6) || (rd != 0 && wr != 0);
`ifdef YSYX_LSU_MISALIGN_CHK_EN
        misal   = ((rd == 3 || rd == 4 || wr == 2) && (addr % 2 != 0)) ||
                  ((rd == 5 || wr == 3) && (off != 0));
`else
        misal   = 1'b0;
`endif
        err = illegal || misal;
        bus = !noop && !err;
        emask = 4'd0; ewdata = 32'd0; eload = 32'd0;
        if (wr == 1) begin emask = 4'(1 << off);       ewdata = (wdata & 32'hFF) * 32'h0101_0101; end
        if (wr == 2) begin emask = 4'(3 << (off & 2)); ewdata = (wdata & 32'hFFFF) * 32'h0001_0001; end
        if (wr == 3) begin emask = 4'hF;               ewdata = wdata; end
        if (rd == 1 || rd == 2) begin
            lane  = (rdata >> (8 * off)) & 32'hFF;
            eload = (rd == 1 && lane >= 128) ? lane - 32'd256 : lane;
        end
        if (rd == 3 || rd == 4) begin
            lane  = (rdata >> (8 * (off & 2))) & 32'hFFFF;
            eload = (rd == 3 && lane >= 32768) ? lane - 32'd65536 : lane;
        end
        if (rd == 5) eload = rdata;
        if (err) eload = 32'd0;

        n_cmp++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL %s idle_ready: got %b want 1", tag, req_ready); end
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_rd_sel = rd; req_wr_sel = wr;
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_rd_sel = 3'($urandom); req_wr_sel = 2'($urandom);
        if (bus) begin
            n_cmp++;
            if (mem_req_valid !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL %s req_cycle1: mem_req_valid=%b req_ready=%b rsp_valid=%b want 1/0/0",
                                  tag, mem_req_valid, req_ready, rsp_valid);
            end
            for (int k = 0; k < ready_dly; k++) @(negedge clk);
            n_cmp++;
            if (mem_req_valid !== 1'b1 || mem_addr !== {addr[31:2], 2'b00} || mem_wen !== (wr != 0) ||
                mem_wmask !== emask) begin
                n_err++; $display("FAIL %s bus_req: valid=%b addr=%h wen=%b mask=%b want 1/%h/%b/%b",
                                  tag, mem_req_valid, mem_addr, mem_wen, mem_wmask,
                                  {addr[31:2], 2'b00}, (wr != 0), emask);
            end
            if (wr != 0) begin
                n_cmp++;
                if (mem_wdata !== ewdata) begin
                    n_err++; $display("FAIL %s wdata: got %h want %h", tag, mem_wdata, ewdata);
                end
            end
            // A response coinciding with acceptance must be ignored.
            mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = ~rdata;
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            n_cmp++;
            if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_err++; $display("FAIL %s wait_state: mem_req_valid=%b rsp_valid=%b req_ready=%b want 0/0/0",
                                  tag, mem_req_valid, rsp_valid, req_ready);
            end
            for (int k = 1; k < rsp_dly; k++) @(negedge clk);
            mem_rsp_valid = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rdata = $urandom;
        end else begin
            n_cmp++;
            if (mem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL %s no_bus: mem_req_valid=%b want 0", tag, mem_req_valid);
            end
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_err !== err || rsp_rdata !== eload || req_ready !== 1'b0) begin
            n_err++; $display("FAIL %s done: rsp_valid=%b err=%b rdata=%h req_ready=%b want 1/%b/%h/0",
                              tag, rsp_valid, rsp_err, rsp_rdata, req_ready, err, eload);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL %s after_done: rsp_valid=%b req_ready=%b want 0/1", tag, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_rd_sel = '0; req_wr_sel = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'd0 || mem_wmask !== 4'd0 || mem_wen !== 1'b0 || mem_addr !== 32'd0) begin
            n_err++; $display("FAIL reset_state: ready=%b mrv=%b rv=%b err=%b rdata=%h mask=%b wen=%b addr=%h",
                              req_ready, mem_req_valid, rsp_valid, rsp_err, rsp_rdata, mem_wmask, mem_wen, mem_addr);
        end
    endtask

    task automatic test_directed();
        run_txn(3'd0, 2'd1, 32'h8000_0003, 32'h1234_56AB, 32'h0, 0, 1, "sb_off3");
        run_txn(3'd1, 2'd0, 32'h1000_0002, 32'h0, 32'h0080_0000, 1, 2, "lb_off2");
        run_txn(3'd2, 2'd0, 32'h1000_0002, 32'h0, 32'h0080_0000, 0, 1, "lbu_off2");
        run_txn(3'd5, 2'd0, 32'h2000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, "lw_zero_wait");
        run_txn(3'd3, 2'd0, 32'h8000_0001, 32'h0, 32'h1234_F678, 0, 1, "lh_odd");
        run_txn(3'd3, 2'd0, 32'h8000_0002, 32'h0, 32'h8001_0000, 2, 3, "lh_hi");
        run_txn(3'd4, 2'd0, 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 1, "lhu_hi");
        run_txn(3'd0, 2'd2, 32'h4000_0002, 32'hCAFE_1234, 32'h0, 0, 1, "sh_hi");
        run_txn(3'd0, 2'd3, 32'h4000_0001, 32'hCAFE_1234, 32'h0, 0, 1, "sw_off1");
    endtask

    task automatic test_noop_illegal();
        run_txn(3'd0, 2'd0, 32'h1234_5678, 32'h1, 32'h0, 0, 1, "noop");
        run_txn(3'd6, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1, "rd_110");
        run_txn(3'd7, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1, "rd_111");
        run_txn(3'd1, 2'd1, 32'h0, 32'h0, 32'h0, 0, 1, "both_sel");
    endtask

    task automatic test_timeout();
        int lat;
        req_valid = 1'b1; req_addr = 32'h3000_0000; req_rd_sel = 3'd5; req_wr_sel = 2'd0;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        lat = 2;
        while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
        n_cmp++;
        if (lat !== 257 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL timeout: latency=%0d err=%b rdata=%h want 257/1/0", lat, rsp_err, rsp_rdata);
        end
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL late_rsp: rv=%b ready=%b mrv=%b want 0/1/0", rsp_valid, req_ready, mem_req_valid);
            end
        end
        mem_rsp_valid = 1'b0;
        run_txn(3'd5, 2'd0, 32'h3000_0004, 32'h0, 32'h0BAD_F00D, 0, 1, "after_timeout");
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 2; s++) begin
            req_valid = 1'b1; req_addr = 32'h5000_0000; req_wdata = 32'h1; req_rd_sel = 3'd0; req_wr_sel = 2'd3;
            @(negedge clk);
            req_valid = 1'b0;
            if (s == 1) begin mem_req_ready = 1'b1; @(negedge clk); mem_req_ready = 1'b0; end
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            n_cmp++;
            if (mem_req_valid !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_err++; $display("FAIL reset_mid_%0d: mrv=%b rv=%b ready=%b want 0/0/1", s, mem_req_valid, rsp_valid, req_ready);
            end
            mem_rsp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            repeat (2) @(negedge clk);
            mem_rsp_valid = 1'b0;
            n_cmp++;
            if (rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_mid_stale_%0d: rv=%b mrv=%b want 0/0", s, rsp_valid, mem_req_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] rd;
        logic [1:0] wr;
        for (int i = 0; i < 60; i++) begin
            rd = 3'($urandom_range(0, 7));
            wr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 0) rd = 3'd0; else wr = 2'd0;
            end
            run_txn(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), "random");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_noop_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
